// File: rtl/edm_tx_pkg.sv
// Package for the EDM transmit arbiter.
// Holds the arbiter FSM state type, the port-index constants and the grant decode helper.
package edm_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam int unsigned PORT_HP = 0;
    localparam int unsigned PORT_LP = 1;

    // One-hot owner for a given state; all-zero when idle.
    function automatic logic [1:0] grant_decode(arb_state_e st);
        logic [1:0] g;
        g = 2'b00;
        unique case (st)
            GNT0:    g[PORT_HP] = 1'b1;
            GNT1:    g[PORT_LP] = 1'b1;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/edm_axis_reg.sv
// Single-stage AXI-Stream output register.
// A load captures all fields and sets tvalid; tvalid drops when the sink takes the beat and no
// new beat loads in the same cycle. Fields hold while tvalid && !tready. The load source must
// only pulse load_i when the register is empty or draining.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   load_i               capture the *_i fields this cycle
//   tdata_i..tuser_i     beat to capture
//   m_tready_i           sink ready
//   m_tvalid_o..m_tuser_o registered stream toward the sink
module edm_axis_reg #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] tdata_i,
    input  logic [KEEP_WIDTH-1:0] tkeep_i,
    input  logic                  tlast_i,
    input  logic [USER_WIDTH-1:0] tuser_i,
    input  logic                  m_tready_i,
    output logic                  m_tvalid_o,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic [KEEP_WIDTH-1:0] m_tkeep_o,
    output logic                  m_tlast_o,
    output logic [USER_WIDTH-1:0] m_tuser_o
);

    logic                  tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic                  tlast_q, tlast_d;
    logic [USER_WIDTH-1:0] tuser_q, tuser_d;

    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        if (load_i) begin
            tvalid_d = 1'b1;
            tdata_d  = tdata_i;
            tkeep_d  = tkeep_i;
            tlast_d  = tlast_i;
            tuser_d  = tuser_i;
        end else if (m_tready_i) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tuser_q  <= '0;
        end else begin
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
        end
    end

    assign m_tvalid_o = tvalid_q;
    assign m_tdata_o  = tdata_q;
    assign m_tkeep_o  = tkeep_q;
    assign m_tlast_o  = tlast_q;
    assign m_tuser_o  = tuser_q;

endmodule

// File: rtl/edm_tx_arb.sv
// Frame-level two-port AXI-Stream transmit arbiter in front of the 10G MAC.
// Port 0 (EDM memory traffic) has priority over port 1 (bulk Ethernet); a granted port keeps
// the output until its tlast beat is accepted, so frames never interleave. One IDLE cycle
// separates frames. Optional starvation guard: define EDM_TX_ARB_STARVE_GUARD_EN to let port 1
// in after HP_BURST_MAX consecutive port-0 frames taken while port 1 was waiting.
// Ports:
//   tx_clk, tx_rst_n       clock, asynchronous active-low reset
//   s0_axis_*              high-priority input stream
//   s1_axis_*              bulk input stream
//   m_axis_*               registered output stream to the MAC
//   grant                  one-hot registered owner, 2'b00 when idle
//   hp_frame_cnt/lp_frame_cnt  wrapping per-port forwarded-frame counts
module edm_tx_arb
    import edm_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH   = 1,
    parameter int unsigned HP_BURST_MAX = 4
) (
    input  logic                  tx_clk,
    input  logic                  tx_rst_n,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    input  logic [USER_WIDTH-1:0] s0_axis_tuser,
    output logic                  s0_axis_tready,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    input  logic [USER_WIDTH-1:0] s1_axis_tuser,
    output logic                  s1_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic [1:0]            grant,
    output logic [15:0]           hp_frame_cnt,
    output logic [15:0]           lp_frame_cnt
);

    arb_state_e  state_q, state_d;
    logic [1:0]  grant_q;
    logic [15:0] hp_cnt_q, hp_cnt_d;
    logic [15:0] lp_cnt_q, lp_cnt_d;

    logic out_free;
    logic acc0, acc1;
    logic hp_done, lp_done;
    logic starve_ovr;

    // The output stage can take a beat when empty or draining this cycle.
    assign out_free       = !m_axis_tvalid || m_axis_tready;
    assign s0_axis_tready = (state_q == GNT0) && out_free;
    assign s1_axis_tready = (state_q == GNT1) && out_free;

    assign acc0    = s0_axis_tvalid && s0_axis_tready;
    assign acc1    = s1_axis_tvalid && s1_axis_tready;
    assign hp_done = acc0 && s0_axis_tlast;
    assign lp_done = acc1 && s1_axis_tlast;

`ifdef EDM_TX_ARB_STARVE_GUARD_EN
    localparam logic [7:0] BurstMax = 8'(HP_BURST_MAX);

    logic [7:0] burst_q, burst_d;

    always_comb begin
        burst_d = burst_q;
        if (lp_done) begin
            burst_d = 8'd0;
        end else if (hp_done && s1_axis_tvalid && (burst_q != 8'hFF)) begin
            burst_d = burst_q + 8'd1;
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            burst_q <= 8'd0;
        end else begin
            burst_q <= burst_d;
        end
    end

    assign starve_ovr = s1_axis_tvalid && (burst_q >= BurstMax);
`else
    logic unused_hp_burst_max;
    assign unused_hp_burst_max = (HP_BURST_MAX == 0);
    assign starve_ovr          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (starve_ovr) begin
                    state_d = GNT1;
                end else if (s0_axis_tvalid) begin
                    state_d = GNT0;
                end else if (s1_axis_tvalid) begin
                    state_d = GNT1;
                end
            end
            GNT0:    if (hp_done) state_d = IDLE;
            GNT1:    if (lp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hp_cnt_d = hp_cnt_q + {15'd0, hp_done};
        lp_cnt_d = lp_cnt_q + {15'd0, lp_done};
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            hp_cnt_q <= 16'd0;
            lp_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_decode(state_d);
            hp_cnt_q <= hp_cnt_d;
            lp_cnt_q <= lp_cnt_d;
        end
    end

    assign grant        = grant_q;
    assign hp_frame_cnt = hp_cnt_q;
    assign lp_frame_cnt = lp_cnt_q;

    // At most one port is granted, so at most one accept is live.
    edm_axis_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH),
        .USER_WIDTH(USER_WIDTH)
    ) u_out_reg (
        .clk_i     (tx_clk),
        .rst_ni    (tx_rst_n),
        .load_i    (acc0 || acc1),
        .tdata_i   (acc1 ? s1_axis_tdata : s0_axis_tdata),
        .tkeep_i   (acc1 ? s1_axis_tkeep : s0_axis_tkeep),
        .tlast_i   (acc1 ? s1_axis_tlast : s0_axis_tlast),
        .tuser_i   (acc1 ? s1_axis_tuser : s0_axis_tuser),
        .m_tready_i(m_axis_tready),
        .m_tvalid_o(m_axis_tvalid),
        .m_tdata_o (m_axis_tdata),
        .m_tkeep_o (m_axis_tkeep),
        .m_tlast_o (m_axis_tlast),
        .m_tuser_o (m_axis_tuser)
    );

endmodule

// File: tb/tb_edm_tx_arb.sv
// Self-checking bench for edm_tx_arb: vector table for reset, single frame and contention,
// hand-written sequences for backpressure, starvation guard and mid-frame reset.
module tb_edm_tx_arb;

    logic        tx_clk = 1'b0;
    logic        tx_rst_n = 1'b0;
    logic [63:0] s0_axis_tdata = '0;
    logic [7:0]  s0_axis_tkeep = 8'hFF;
    logic        s0_axis_tvalid = 1'b0;
    logic        s0_axis_tlast = 1'b0;
    logic [0:0]  s0_axis_tuser = 1'b0;
    logic        s0_axis_tready;
    logic [63:0] s1_axis_tdata = '0;
    logic [7:0]  s1_axis_tkeep = 8'h0F;
    logic        s1_axis_tvalid = 1'b0;
    logic        s1_axis_tlast = 1'b0;
    logic [0:0]  s1_axis_tuser = 1'b1;
    logic        s1_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
    logic        m_axis_tready = 1'b1;
    logic [1:0]  grant;
    logic [15:0] hp_frame_cnt;
    logic [15:0] lp_frame_cnt;

    int passed = 0;
    int total  = 0;

    always #5 tx_clk = ~tx_clk;

    edm_tx_arb #(
        .DATA_WIDTH  (64),
        .KEEP_WIDTH  (8),
        .USER_WIDTH  (1),
        .HP_BURST_MAX(2)
    ) dut (
        .tx_clk        (tx_clk),
        .tx_rst_n      (tx_rst_n),
        .s0_axis_tdata (s0_axis_tdata),
        .s0_axis_tkeep (s0_axis_tkeep),
        .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tlast (s0_axis_tlast),
        .s0_axis_tuser (s0_axis_tuser),
        .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata (s1_axis_tdata),
        .s1_axis_tkeep (s1_axis_tkeep),
        .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tlast (s1_axis_tlast),
        .s1_axis_tuser (s1_axis_tuser),
        .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .grant         (grant),
        .hp_frame_cnt  (hp_frame_cnt),
        .lp_frame_cnt  (lp_frame_cnt)
    );

    typedef struct {
        logic        rst_n;
        logic        s0v;
        logic [63:0] s0d;
        logic        s0l;
        logic        s1v;
        logic [63:0] s1d;
        logic        s1l;
        logic        mrdy;
        logic        r0;   // expected s0 tready before the edge
        logic        r1;   // expected s1 tready before the edge
        logic        mv;   // expected m_axis_tvalid after the edge
        logic [63:0] md;
        logic        ml;
        logic [1:0]  g;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic s0v, logic [63:0] s0d, logic s0l,
                                logic s1v, logic [63:0] s1d, logic s1l, logic mrdy,
                                logic r0, logic r1, logic mv, logic [63:0] md, logic ml,
                                logic [1:0] g);
        vec_t v;
        v.rst_n = rst_n; v.s0v = s0v; v.s0d = s0d; v.s0l = s0l;
        v.s1v = s1v; v.s1d = s1d; v.s1l = s1l; v.mrdy = mrdy;
        v.r0 = r0; v.r1 = r1; v.mv = mv; v.md = md; v.ml = ml; v.g = g;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Apply vecs[lo..hi]; assumes the caller sits just after a rising edge.
    task automatic apply_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            vec_t v;
            v = vecs[i];
            tx_rst_n       = v.rst_n;
            s0_axis_tvalid = v.s0v; s0_axis_tdata = v.s0d; s0_axis_tlast = v.s0l;
            s1_axis_tvalid = v.s1v; s1_axis_tdata = v.s1d; s1_axis_tlast = v.s1l;
            m_axis_tready  = v.mrdy;
            #1;
            chk($sformatf("v%0d_s0_tready", i), 64'(s0_axis_tready), 64'(v.r0));
            chk($sformatf("v%0d_s1_tready", i), 64'(s1_axis_tready), 64'(v.r1));
            @(posedge tx_clk);
            #1;
            chk($sformatf("v%0d_tvalid", i), 64'(m_axis_tvalid), 64'(v.mv));
            chk($sformatf("v%0d_grant", i), 64'(grant), 64'(v.g));
            if (v.mv || !v.rst_n) begin
                chk($sformatf("v%0d_tdata", i), m_axis_tdata, v.md);
                chk($sformatf("v%0d_tlast", i), 64'(m_axis_tlast), 64'(v.ml));
            end
        end
    endtask

    task automatic do_reset();
        tx_rst_n       = 1'b0;
        s0_axis_tvalid = 1'b0;
        s1_axis_tvalid = 1'b0;
        m_axis_tready  = 1'b1;
        @(posedge tx_clk);
        #1;
        tx_rst_n = 1'b1;
    endtask

    // Send an n-beat port-1 frame with data base+i, optionally toggling m_axis_tready, and
    // check order, tlast, tkeep/tuser passthrough and hold-while-stalled.
    task automatic send_p1(input int n, input logic [63:0] base, input bit toggle,
                           input string tag);
        int          tx = 0;
        int          rx = 0;
        int          cyc = 0;
        bit          prev_stall = 0;
        logic [63:0] prev_data = '0;
        while (rx < n && cyc < 80) begin
            if (prev_stall) begin
                chk({tag, "_hold_valid"}, 64'(m_axis_tvalid), 64'd1);
                chk({tag, "_hold_data"}, m_axis_tdata, prev_data);
            end
            m_axis_tready  = toggle ? (cyc % 2 == 0) : 1'b1;
            s1_axis_tvalid = (tx < n);
            s1_axis_tdata  = base + 64'(tx);
            s1_axis_tlast  = (tx == n - 1);
            #1;
            if (m_axis_tvalid && m_axis_tready) begin
                chk($sformatf("%s_data%0d", tag, rx), m_axis_tdata, base + 64'(rx));
                chk($sformatf("%s_last%0d", tag, rx), 64'(m_axis_tlast), 64'(rx == n - 1));
                if (rx == 0) begin
                    chk({tag, "_tkeep"}, 64'(m_axis_tkeep), 64'h0F);
                    chk({tag, "_tuser"}, 64'(m_axis_tuser), 64'd1);
                end
                rx++;
            end
            if (s1_axis_tvalid && s1_axis_tready) tx++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            @(posedge tx_clk);
            #1;
            cyc++;
        end
        s1_axis_tvalid = 1'b0;
        s1_axis_tlast  = 1'b0;
        m_axis_tready  = 1'b1;
        chk({tag, "_beats"}, 64'(rx), 64'(n));
    endtask

    initial begin
        int sf_lo, sf_hi, ct_lo, ct_hi;
        int exp_order[6];
        int order[6];
        int got;
        int p0n;

        // Reset with both sources requesting.
        vecs.push_back(mk(0, 1, 64'h11, 0, 1, 64'h22, 0, 1, 0, 0, 0, 64'h0, 0, 2'b00));
        vecs.push_back(mk(0, 1, 64'h11, 0, 1, 64'h22, 0, 1, 0, 0, 0, 64'h0, 0, 2'b00));
        // Single 8-beat port-0 frame: arbitration cycle, then one beat per cycle.
        sf_lo = vecs.size();
        vecs.push_back(mk(1, 1, 64'd1, 0, 0, 64'h0, 0, 1, 0, 0, 0, 64'h0, 0, 2'b01));
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mk(1, 1, 64'(k), k == 8, 0, 64'h0, 0, 1,
                              1, 0, 1, 64'(k), k == 8, (k == 8) ? 2'b00 : 2'b01));
        end
        vecs.push_back(mk(1, 0, 64'h0, 0, 0, 64'h0, 0, 1, 0, 0, 0, 64'h0, 0, 2'b00));
        sf_hi = vecs.size() - 1;
        // Contention: port 0 whole frame, one IDLE cycle, then port 1 frame.
        ct_lo = vecs.size();
        vecs.push_back(mk(1, 1, 64'hA1, 0, 1, 64'hB1, 0, 1, 0, 0, 0, 64'h0,  0, 2'b01));
        vecs.push_back(mk(1, 1, 64'hA1, 0, 1, 64'hB1, 0, 1, 1, 0, 1, 64'hA1, 0, 2'b01));
        vecs.push_back(mk(1, 1, 64'hA2, 0, 1, 64'hB1, 0, 1, 1, 0, 1, 64'hA2, 0, 2'b01));
        vecs.push_back(mk(1, 1, 64'hA3, 1, 1, 64'hB1, 0, 1, 1, 0, 1, 64'hA3, 1, 2'b00));
        vecs.push_back(mk(1, 0, 64'h0,  0, 1, 64'hB1, 0, 1, 0, 0, 0, 64'h0,  0, 2'b10));
        vecs.push_back(mk(1, 0, 64'h0,  0, 1, 64'hB1, 0, 1, 0, 1, 1, 64'hB1, 0, 2'b10));
        vecs.push_back(mk(1, 0, 64'h0,  0, 1, 64'hB2, 1, 1, 0, 1, 1, 64'hB2, 1, 2'b00));
        vecs.push_back(mk(1, 0, 64'h0,  0, 0, 64'h0,  0, 1, 0, 0, 0, 64'h0,  0, 2'b00));
        ct_hi = vecs.size() - 1;

        #1;
        apply_range(0, 1);
        chk("rst_hp_cnt", 64'(hp_frame_cnt), 64'd0);
        chk("rst_lp_cnt", 64'(lp_frame_cnt), 64'd0);

        apply_range(sf_lo, sf_hi);
        chk("single_hp_cnt", 64'(hp_frame_cnt), 64'd1);

        apply_range(ct_lo, ct_hi);
        chk("contend_hp_cnt", 64'(hp_frame_cnt), 64'd2);
        chk("contend_lp_cnt", 64'(lp_frame_cnt), 64'd1);

        // Backpressure: 10-beat port-1 frame with tready toggling.
        send_p1(10, 64'h100, 1'b1, "bp");
        chk("bp_lp_cnt", 64'(lp_frame_cnt), 64'd2);

        // Starvation: continuous 1-beat port-0 frames with port 1 always pending.
`ifdef EDM_TX_ARB_STARVE_GUARD_EN
        exp_order = '{0, 0, 1, 0, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 0, 0};
`endif
        do_reset();
        got = 0;
        p0n = 0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            s0_axis_tvalid = 1'b1; s0_axis_tdata = 64'hA0 + 64'(p0n); s0_axis_tlast = 1'b1;
            s1_axis_tvalid = 1'b1; s1_axis_tdata = 64'hB0; s1_axis_tlast = 1'b1;
            m_axis_tready  = 1'b1;
            #1;
            if (m_axis_tvalid) begin
                order[got] = (m_axis_tdata[7:4] == 4'hB) ? 1 : 0;
                got++;
            end
            if (s0_axis_tready) p0n++;
            @(posedge tx_clk);
            #1;
        end
        chk("guard_frames", 64'(got), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("guard_order%0d", i), 64'(order[i]), 64'(exp_order[i]));
        end

        // Mid-frame reset at beat 3 of a 6-beat port-0 frame.
        do_reset();
        s0_axis_tvalid = 1'b1; s0_axis_tdata = 64'hC1; s0_axis_tlast = 1'b0;
        @(posedge tx_clk);
        #1;
        for (int k = 1; k <= 3; k++) begin
            s0_axis_tdata = 64'hC0 + 64'(k);
            @(posedge tx_clk);
            #1;
        end
        chk("mid_beat3_valid", 64'(m_axis_tvalid), 64'd1);
        chk("mid_beat3_data", m_axis_tdata, 64'hC3);
        #2;
        tx_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst_data", m_axis_tdata, 64'd0);
        chk("mid_rst_grant", 64'(grant), 64'd0);
        chk("mid_rst_s0_ready", 64'(s0_axis_tready), 64'd0);
        chk("mid_rst_hp_cnt", 64'(hp_frame_cnt), 64'd0);
        s0_axis_tvalid = 1'b0;
        @(posedge tx_clk);
        #1;
        chk("mid_hold_valid", 64'(m_axis_tvalid), 64'd0);
        tx_rst_n = 1'b1;
        @(posedge tx_clk);
        #1;
        send_p1(4, 64'hD0, 1'b0, "post_rst");
        chk("post_rst_lp_cnt", 64'(lp_frame_cnt), 64'd1);
        chk("post_rst_hp_cnt", 64'(hp_frame_cnt), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
